// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg: shared constants and state encoding for the instruction fetch stage.
//   XLEN      - datapath / PC width
//   ILEN      - instruction word width
//   RESET_PC  - PC loaded on reset
//   PC_INC    - sequential PC step
//   fetch_state_e - fetch FSM states
package ifu_fetch_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ILEN   = 32;
  localparam int unsigned PC_INC = 4;

  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: groups the fetch stage's memory, decode and redirect signals.
//   imem_req_*  - request channel to instruction memory (fetch drives valid/addr)
//   imem_rsp_*  - single-cycle response pulse from instruction memory
//   id_*        - {inst, pc} handshake towards decode
//   redirect_*  - PC change request from execute
// Modports: master = fetch stage, slave = its environment (memory/decode/execute).
interface ifu_fetch_if #(
  parameter int unsigned XLEN = ifu_fetch_pkg::XLEN
);
  import ifu_fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            id_valid;
  logic            id_ready;
  logic [ILEN-1:0] id_inst;
  logic [XLEN-1:0] id_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ifu_pc_reg.sv
// ifu_pc_reg: program counter register with redirect load and sequential increment.
//   clk, rst   - clock, synchronous active-high reset (loads RESET_PC)
//   load_i     - load load_pc_i (word aligned); wins over inc_i
//   load_pc_i  - redirect target, bits [1:0] ignored
//   inc_i      - advance pc by PC_INC, wrapping modulo 2^XLEN
//   pc_o       - current pc
module ifu_pc_reg
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = ifu_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ifu_fetch_pkg::RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [XLEN-1:0] load_pc_i,
  input  logic            inc_i,
  output logic [XLEN-1:0] pc_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Next pc: redirect target first, then sequential step.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i & ~XLEN'(3);
    end else if (inc_i) begin
      pc_d = pc_q + XLEN'(PC_INC);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch stage.
//   clk, rst - clock, synchronous active-high reset
//   bus      - ifu_fetch_if.master: imem request/response, decode handshake, redirect
// One request is in flight at a time; the returned word is held with its pc until
// decode takes it. A redirect replaces the pc and squashes whatever is in flight or
// held; a response already owed to the old pc is swallowed via the drop flag.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = ifu_fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(ifu_fetch_pkg::RESET_PC)
) (
  input  logic        clk,
  input  logic        rst,
  ifu_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic            drop_q, drop_d;
  logic [ILEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic            pc_inc;
  logic [XLEN-1:0] pc;

  ifu_pc_reg #(
    .XLEN    (XLEN),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (bus.redirect_valid),
    .load_pc_i(bus.redirect_pc),
    .inc_i    (pc_inc),
    .pc_o     (pc)
  );

  // Next-state logic; redirect_valid reloads the pc inside ifu_pc_reg in every state.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    inst_d  = inst_q;
    id_pc_d = id_pc_q;
    pc_inc  = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) begin
          state_d = S_WAIT;
          // Request left with the old pc while the pc is being redirected.
          drop_d  = bus.redirect_valid;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (bus.redirect_valid || drop_q) begin
            state_d = S_REQ;
            drop_d  = 1'b0;
          end else begin
            inst_d  = bus.imem_rsp_data;
            id_pc_d = pc;
            state_d = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (bus.redirect_valid) begin
          state_d = S_REQ;
        end else if (bus.id_ready) begin
          pc_inc  = 1'b1;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
      inst_q  <= '0;
      id_pc_q <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
      inst_q  <= inst_d;
      id_pc_q <= id_pc_d;
    end
  end

  // Valids are gated combinationally so nothing is offered during reset or squash.
  assign bus.imem_req_valid = (state_q == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = (state_q == S_OUT) && !bus.redirect_valid && !rst;
  assign bus.id_inst        = inst_q;
  assign bus.id_pc          = id_pc_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: directed vector table, hand-written reset/wrap sequences and a
// randomized run checked against a transaction-level fetch model.
module tb_ifu_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ifu_fetch_if bus ();

  ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic        ir;
    logic        xv;
    logic [31:0] xpc;
    logic        erv;
    logic [31:0] era;
    logic        eiv;
    logic [31:0] eii;
    logic [31:0] eip;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rr, input logic rv, input logic [31:0] rd,
                       input logic ir, input logic xv, input logic [31:0] xpc);
    bus.imem_req_ready = rr;
    bus.imem_rsp_valid = rv;
    bus.imem_rsp_data  = rd;
    bus.id_ready       = ir;
    bus.redirect_valid = xv;
    bus.redirect_pc    = xpc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(input logic rr, input logic rv, input logic [31:0] rd,
                               input logic ir, input logic xv, input logic [31:0] xpc,
                               input logic erv, input logic [31:0] era, input logic eiv,
                               input logic [31:0] eii, input logic [31:0] eip);
    vec_t v;
    v.rr = rr; v.rv = rv; v.rd = rd; v.ir = ir; v.xv = xv; v.xpc = xpc;
    v.erv = erv; v.era = era; v.eiv = eiv; v.eii = eii; v.eip = eip;
    vecs.push_back(v);
  endfunction

  // Memory contents used by the random run: any deterministic word per address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  initial begin
    logic [31:0] exp_pc, paddr, prev_inst, prev_pc, xpc;
    logic        pend, hold, rr, ir, xv, rv;
    logic [31:0] rd;
    int          cnt, xfers;

    // Reset: valids gated, id registers cleared.
    rst = 1'b1;
    drive(1, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("rst req_valid", 32'(bus.imem_req_valid), 0);
    check("rst id_valid", 32'(bus.id_valid), 0);
    tick();
    @(negedge clk);
    check("rst id_inst", bus.id_inst, 0);
    check("rst id_pc", bus.id_pc, 0);
    tick();
    rst = 1'b0;

    // rr, rv, rd, ir, xv, xpc | erv, era | eiv, eii, eip
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0000, 0,0,0);
    addv(1,1,32'h0050_0093,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h0050_0093,32'h8000_0000);
    addv(1,0,32'h0,0,0,0, 1,32'h8000_0004, 0,0,0);
    addv(1,1,32'h00a0_0113,0,0,0, 0,0, 0,0,0);
    for (int i = 0; i < 5; i++) addv(1,0,32'h0,0,0,0, 0,0, 1,32'h00a0_0113,32'h8000_0004);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h00a0_0113,32'h8000_0004);
    addv(1,0,32'h0,1,1,32'h8000_0200, 1,32'h8000_0008, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 0,0,0);
    addv(1,1,32'hdead_beef,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0200, 0,0,0);
    addv(1,0,32'h0,1,1,32'h8000_0103, 0,0, 0,0,0);
    addv(1,1,32'h1111_1111,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0100, 0,0,0);
    addv(1,1,32'h0020_8193,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h0020_8193,32'h8000_0100);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0104, 0,0,0);
    addv(1,1,32'h4020_8233,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,0,0,0, 0,0, 1,32'h4020_8233,32'h8000_0104);
    addv(1,0,32'h0,1,1,32'h8000_0300, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0300, 0,0,0);
    addv(1,1,32'h0000_006f,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h0000_006f,32'h8000_0300);
    addv(0,0,32'h0,1,1,32'h8000_0400, 1,32'h8000_0304, 0,0,0);
    addv(0,0,32'h0,1,0,0, 1,32'h8000_0400, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0400, 0,0,0);
    addv(1,1,32'h00c2_8293,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h00c2_8293,32'h8000_0400);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0404, 0,0,0);
    addv(1,1,32'h2222_2222,1,1,32'h8000_0500, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0500, 0,0,0);
    addv(1,1,32'hfff3_0313,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'hfff3_0313,32'h8000_0500);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0504, 0,0,0);
    addv(1,0,32'h0,1,1,32'h8000_0600, 0,0, 0,0,0);
    addv(1,0,32'h0,1,1,32'h8000_0700, 0,0, 0,0,0);
    addv(1,1,32'h3333_3333,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 1,32'h8000_0700, 0,0,0);
    addv(1,1,32'h0000_0013,1,0,0, 0,0, 0,0,0);
    addv(1,0,32'h0,1,0,0, 0,0, 1,32'h0000_0013,32'h8000_0700);
    addv(0,1,32'h4444_4444,1,0,0, 1,32'h8000_0704, 0,0,0);

    foreach (vecs[i]) begin
      drive(vecs[i].rr, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].xv, vecs[i].xpc);
      @(negedge clk);
      check($sformatf("vec%0d req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].erv));
      if (vecs[i].erv) check($sformatf("vec%0d req_addr", i), bus.imem_req_addr, vecs[i].era);
      check($sformatf("vec%0d id_valid", i), 32'(bus.id_valid), 32'(vecs[i].eiv));
      if (vecs[i].eiv) begin
        check($sformatf("vec%0d id_inst", i), bus.id_inst, vecs[i].eii);
        check($sformatf("vec%0d id_pc", i), bus.id_pc, vecs[i].eip);
      end
      tick();
    end

    // Reset during S_WAIT, then a stale response before the new request is accepted.
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst req_addr", bus.imem_req_addr, 32'h8000_0704);
    tick();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("midrst req_valid", 32'(bus.imem_req_valid), 0);
    tick();
    rst = 1'b0;
    drive(0, 1, 32'h5555_5555, 1, 0, 0);
    @(negedge clk);
    check("stale req_valid", 32'(bus.imem_req_valid), 1);
    check("stale req_addr", bus.imem_req_addr, 32'h8000_0000);
    check("stale id_pc", bus.id_pc, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("after stale req_valid", 32'(bus.imem_req_valid), 1);
    check("after stale id_valid", 32'(bus.id_valid), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 32'h0050_0093, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("restart id_valid", 32'(bus.id_valid), 1);
    check("restart id_inst", bus.id_inst, 32'h0050_0093);
    check("restart id_pc", bus.id_pc, 32'h8000_0000);
    tick();

    // PC wrap: redirect (low bits ignored) to the last word, then a transfer.
    drive(0, 0, 0, 1, 1, 32'hFFFF_FFFE);
    @(negedge clk);
    check("wrap squash id_valid", 32'(bus.id_valid), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap req_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
    tick();
    drive(0, 1, 32'h0010_0073, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    check("wrap id_pc", bus.id_pc, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("wrap next req_addr", bus.imem_req_addr, 32'h0000_0000);
    tick();

    // Randomized run: memory answers each accepted request after 1..3 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_pc = 32'h8000_0000;
    pend = 1'b0; hold = 1'b0; cnt = 0; xfers = 0;
    paddr = '0; prev_inst = '0; prev_pc = '0;
    for (int c = 0; c < 4000; c++) begin
      rr = ($urandom_range(0, 3) != 0);
      ir = ($urandom_range(0, 2) != 0);
      xv = ($urandom_range(0, 15) == 0);
      xpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rv = 1'b0;
      rd = $urandom;
      if (pend) begin
        if (cnt == 0) begin
          rv = 1'b1;
          rd = memf(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
      drive(rr, rv, rd, ir, xv, xpc);
      @(negedge clk);
      if (hold) begin
        check("rnd hold inst", bus.id_inst, prev_inst);
        check("rnd hold pc", bus.id_pc, prev_pc);
        check("rnd hold valid", 32'(bus.id_valid || xv), 1);
      end
      if (xv) check("rnd squash id_valid", 32'(bus.id_valid), 0);
      if (bus.imem_req_valid) begin
        check("rnd one outstanding", 32'(pend), 0);
        if (rr) begin
          check("rnd req_addr", bus.imem_req_addr, exp_pc);
          pend  = 1'b1;
          cnt   = $urandom_range(0, 2);
          paddr = bus.imem_req_addr;
        end
      end
      if (bus.id_valid && ir) begin
        check("rnd id_pc", bus.id_pc, exp_pc);
        check("rnd id_inst", bus.id_inst, memf(exp_pc));
        exp_pc = exp_pc + 32'd4;
        xfers++;
      end
      hold      = bus.id_valid && !ir && !xv;
      prev_inst = bus.id_inst;
      prev_pc   = bus.id_pc;
      if (xv) exp_pc = xpc & ~32'd3;
      tick();
    end
    check("rnd progress", 32'(xfers >= 100), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage directly upstream of decode and the immediate generator.
- Owns the PC and issues one instruction-memory request at a time.
- Captures the returned 32-bit instruction and presents the {inst, pc} pair to decode over a valid/ready handshake.
- Accepts PC redirects from execute (branches/jumps) and squashes any in-flight or held instruction.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response data valid (one-cycle pulse)
imem_rsp_data  in  32  fetched instruction word
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts instruction
id_inst  out  32  instruction to decode / immediate generator
id_pc  out  XLEN  PC of id_inst
redirect_valid  in  1  execute requests PC change
redirect_pc  in  XLEN  new PC; bits [1:0] ignored, forced to 0

Behaviour:
- State machine with three states.
  - S_REQ: imem_req_valid=1, imem_req_addr=pc.
  - S_WAIT: awaiting response.
  - S_OUT: id_valid asserted, holding the instruction for decode.
- Reset (rst=1 at an edge):
  - state<=S_REQ, pc<=RESET_PC, drop<=0, id_inst<=0, id_pc<=0.
  - While rst=1: imem_req_valid=0 and id_valid=0 (combinationally gated).
- Transitions without redirect:
  - S_REQ & imem_req_ready -> S_WAIT.
  - S_WAIT & imem_rsp_valid -> latch id_inst<=imem_rsp_data, id_pc<=pc; -> S_OUT.
  - S_OUT & id_ready -> pc<=pc+4 (wraps modulo 2^XLEN); -> S_REQ.
- Handshake rules:
  - imem_req_valid stays high in S_REQ until accepted; address is stable while valid.
  - id_valid, id_inst and id_pc are stable until the id handshake completes.
  - id_valid = (state==S_OUT) & !redirect_valid & !rst.
- imem_rsp_valid outside S_WAIT is ignored. This covers stale responses after reset.
- Latency: with zero-wait memory (req_ready=1, rsp one cycle after accept), request to id_valid takes 2 cycles. Throughput is 1 instruction per 3 cycles with id_ready=1. Only one request is outstanding at a time.
- Redirect (highest priority; pc<=redirect_pc & ~3 in all cases):
  - S_REQ, no handshake: stay S_REQ; the next request uses the new pc.
  - S_REQ with handshake in the same cycle: the request went to the old pc, so drop<=1 and -> S_WAIT.
  - S_WAIT, no rsp: drop<=1, stay S_WAIT.
  - S_WAIT with rsp in the same cycle: discard the response, -> S_REQ.
  - S_OUT: discard the held instruction (id_valid is already low this cycle, so no transfer occurs), -> S_REQ.
- Drop flag:
  - S_WAIT & rsp & drop: discard data, drop<=0, -> S_REQ. pc already holds the redirect target.
  - A second redirect while drop=1 overwrites pc; drop stays 1.
- Reset mid-operation: rst overrides all; an in-flight request is abandoned, and its late response is ignored because state is S_REQ.

Decomposition:
- Shared package (npc defines header): RESET_PC value, XLEN, fetch state encodings (S_REQ=2'd0, S_WAIT=2'd1, S_OUT=2'd2), PC increment constant 4.
- One natural sub-module: ifu_pc_reg.
  - Holds pc with reset-to-RESET_PC, load (redirect) and increment enables.
  - Redirect load has priority over increment.
- FSM, drop flag and the output registers stay in ifu_fetch.

Test Plan:
1. Reset then zero-wait memory returning 32'h00500093, id_ready=1: first imem_req_addr=0x80000000; id_inst=0x00500093, id_pc=0x80000000. The next request is at 0x80000004.
2. Backpressure: id_ready=0 for 5 cycles in S_OUT: id_valid stays 1 and id_inst/id_pc stay constant with no new imem request. Raising id_ready advances the PC to +4.
3. Redirect while in S_WAIT (redirect_pc=0x80000103): the stale response is dropped with no id_valid. The next request goes to 0x80000100, and that response is delivered with id_pc=0x80000100.
4. Redirect in the same cycle as the imem request handshake at 0x80000008 to 0x80000200: the 0x80000008 response is discarded. The next request goes to 0x80000200.
5. Redirect in S_OUT with id_ready=1 in the same cycle: id_valid=0 that cycle, the held instruction is never transferred, and the next request goes to the redirect target.
6. rst asserted during S_WAIT, then an imem_rsp_valid pulse arriving after rst deasserts but before the new request is accepted: the pulse is ignored. The fetch restarts at 0x80000000. PC wrap check: pc=0xFFFFFFFC followed by a handshake gives pc=0x00000000.
